// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    // Double-dabble digit correction: add 3 to any digit >= 5 before a shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2, minimum 1; sizes the iteration counter as clog2(WIDTH+1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction cell: din + 3 when din >= 5, else din.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Pure combinational add-3 correction
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) dout = din + ADJ_ADD;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// start/done handshake; results only change on the done cycle.
// Optional macro BCD_SIGNED_EN: treat bin as two's complement, convert the
// magnitude and report the sign on neg.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf,
    output logic                          neg
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_sh;
    logic               carry_out;
    logic [WIDTH-1:0]   load_val;
    logic               load_sign;
    logic               last;

    // Every digit is corrected in parallel before the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit has weight 10^DIGITS; dropping it keeps the result mod 10^DIGITS
    assign {carry_out, scratch_sh} = {adj, shreg_q[WIDTH-1]};
    assign last                    = (count_q == CNT_W'(1));

`ifdef BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;

    // Negate at load so the iteration count is unchanged; -2^(W-1) maps to 2^(W-1) unsigned
    always_comb begin
        load_sign = bin[WIDTH-1];
        load_val  = load_sign ? ('0 - bin) : bin;
    end
`else
    always_comb begin
        load_sign = 1'b0;
        load_val  = bin;
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
`ifdef BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    // Next-state: IDLE waits for start, SHIFT runs WIDTH iterations
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last)  state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // Datapath and result updates; results are committed only on the final shift
    always_comb begin
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = load_val;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    count_d   = CNT_W'(WIDTH);
`ifdef BCD_SIGNED_EN
                    sign_d    = load_sign;
`endif
                end
            end
            ST_SHIFT: begin
                shreg_d   = shreg_q << 1;
                scratch_d = scratch_sh;
                sticky_d  = sticky_q | carry_out;
                count_d   = count_q - CNT_W'(1);
                if (last) begin
                    bcd_d  = scratch_sh;
                    ovf_d  = sticky_q | carry_out;
                    done_d = 1'b1;
`ifdef BCD_SIGNED_EN
                    neg_d  = sign_q;
`endif
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
`ifdef BCD_SIGNED_EN
    assign neg  = neg_q;
`else
    assign neg  = 1'b0 & load_sign;
`endif

endmodule
